// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 4-register vector pipeline:
// freeze/stall/flush control, EX forwarding selects, data-memory handshake.
module pipe_hazard_ctrl #(
  parameter int unsigned AW          = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AW-1:0]    IDEX_A1_i,
  input  logic [AW-1:0]    IDEX_A2_i,
  input  logic [AW-1:0]    IDEX_A3_i,
  input  logic             IDEX_RF_WE_i,
  input  logic             IDEX_WBSelect_i,
  input  logic [AW-1:0]    ID_A1_i,
  input  logic [AW-1:0]    ID_A2_i,
  input  logic             ID_Use1_i,
  input  logic             ID_Use2_i,
  input  logic [AW-1:0]    EXMEM_A3_i,
  input  logic             EXMEM_RF_WE_i,
  input  logic             EXMEM_WBSelect_i,
  input  logic             EXMEM_MemWE_i,
  input  logic [AW-1:0]    MEMWB_A3_i,
  input  logic             MEMWB_RF_WE_i,
  input  logic             Branch_Taken_i,
  input  logic             Mem_Ready_i,
  output logic             Mem_Req_o,
  output logic             Freeze_o,
  output logic             Bubble_MEMWB_o,
  output logic             Stall_FD_o,
  output logic             Flush_IFID_o,
  output logic             Flush_IDEX_o,
  output logic [1:0]       FwdA_o,
  output logic [1:0]       FwdB_o,
  output logic             Mem_Err_o,
  output logic [1:0]       State_o,
  output logic [CNT_W-1:0] Stall_Cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_t;

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT) + 1;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             err_q;
  logic [CNT_W-1:0] scnt_q;

  logic       memop, freeze, mem_req, load_use;
  logic       stall_fd, fl_ifid, fl_idex;
  logic [1:0] fwd_a, fwd_b;

  assign memop = EXMEM_WBSelect_i | EXMEM_MemWE_i;

  // The request is issued only from RUN, so an op held in EX/MEM while waiting
  // never sees a second request; the next op is requested after release.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    freeze  = 1'b0;
    mem_req = 1'b0;
    unique case (state_q)
      RUN: begin
        if (memop) begin
          mem_req = 1'b1;
          if (!Mem_Ready_i) begin
            freeze  = 1'b1;
            wcnt_d  = WCW'(1);
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (Mem_Ready_i) begin
          wcnt_d  = '0;
          state_d = RUN;
        end else begin
          freeze = 1'b1;
          wcnt_d = wcnt_q + WCW'(1);
          if (wcnt_q == WCW'(MEM_TIMEOUT - 1)) state_d = ERR;
        end
      end
      ERR:     freeze = 1'b1;
      default: state_d = RUN;
    endcase
  end

  assign load_use = IDEX_WBSelect_i & IDEX_RF_WE_i &
                    ((ID_Use1_i & (ID_A1_i == IDEX_A3_i)) |
                     (ID_Use2_i & (ID_A2_i == IDEX_A3_i)));

  // A taken branch squashes the decode instr, so it wins over load-use.
  always_comb begin
    stall_fd = 1'b0;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    if (!freeze) begin
      if (Branch_Taken_i) begin
        fl_ifid = 1'b1;
        fl_idex = 1'b1;
      end else if (load_use) begin
        stall_fd = 1'b1;
        fl_idex  = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (EXMEM_RF_WE_i && !EXMEM_WBSelect_i && (EXMEM_A3_i == IDEX_A1_i)) fwd_a = 2'b01;
    else if (MEMWB_RF_WE_i && (MEMWB_A3_i == IDEX_A1_i))                 fwd_a = 2'b10;
    if (EXMEM_RF_WE_i && !EXMEM_WBSelect_i && (EXMEM_A3_i == IDEX_A2_i)) fwd_b = 2'b01;
    else if (MEMWB_RF_WE_i && (MEMWB_A3_i == IDEX_A2_i))                 fwd_b = 2'b10;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_d == ERR) err_q <= 1'b1;
      if ((freeze | stall_fd) && (scnt_q != '1)) scnt_q <= scnt_q + CNT_W'(1);
    end
  end

  assign Mem_Req_o      = RST & mem_req;
  assign Freeze_o       = RST & freeze;
  assign Bubble_MEMWB_o = RST & freeze;
  assign Stall_FD_o     = RST & stall_fd;
  assign Flush_IFID_o   = RST & fl_ifid;
  assign Flush_IDEX_o   = RST & fl_idex;
  assign FwdA_o         = RST ? fwd_a : 2'b00;
  assign FwdB_o         = RST ? fwd_b : 2'b00;
  assign Mem_Err_o      = err_q;
  assign State_o        = state_q;
  assign Stall_Cnt_o    = scnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle
// sequences, expected records queued at drive time and popped at sample time.
module tb_pipe_hazard_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned MT = 4;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] a1, a2, a3;
    logic          idex_we, idex_wb;
    logic [AW-1:0] id_a1, id_a2;
    logic          use1, use2;
    logic [AW-1:0] exmem_a3;
    logic          exmem_we, exmem_wb, exmem_mwe;
    logic [AW-1:0] memwb_a3;
    logic          memwb_we, branch, ready;
  } in_t;

  typedef struct packed {
    logic          req, freeze, bubble, stall_fd, fl_ifid, fl_idex;
    logic [1:0]    fwda, fwdb;
    logic          err;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    in_t   vi;
    exp_t  ve;
    string nm;
  } vec_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST;
  logic [AW-1:0] IDEX_A1_i, IDEX_A2_i, IDEX_A3_i, ID_A1_i, ID_A2_i, EXMEM_A3_i, MEMWB_A3_i;
  logic          IDEX_RF_WE_i, IDEX_WBSelect_i, ID_Use1_i, ID_Use2_i;
  logic          EXMEM_RF_WE_i, EXMEM_WBSelect_i, EXMEM_MemWE_i, MEMWB_RF_WE_i;
  logic          Branch_Taken_i, Mem_Ready_i;
  logic          Mem_Req_o, Freeze_o, Bubble_MEMWB_o, Stall_FD_o, Flush_IFID_o, Flush_IDEX_o;
  logic [1:0]    FwdA_o, FwdB_o, State_o;
  logic          Mem_Err_o;
  logic [CW-1:0] Stall_Cnt_o;

  pipe_hazard_ctrl #(.AW(AW), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .IDEX_A1_i(IDEX_A1_i), .IDEX_A2_i(IDEX_A2_i), .IDEX_A3_i(IDEX_A3_i),
    .IDEX_RF_WE_i(IDEX_RF_WE_i), .IDEX_WBSelect_i(IDEX_WBSelect_i),
    .ID_A1_i(ID_A1_i), .ID_A2_i(ID_A2_i), .ID_Use1_i(ID_Use1_i), .ID_Use2_i(ID_Use2_i),
    .EXMEM_A3_i(EXMEM_A3_i), .EXMEM_RF_WE_i(EXMEM_RF_WE_i),
    .EXMEM_WBSelect_i(EXMEM_WBSelect_i), .EXMEM_MemWE_i(EXMEM_MemWE_i),
    .MEMWB_A3_i(MEMWB_A3_i), .MEMWB_RF_WE_i(MEMWB_RF_WE_i),
    .Branch_Taken_i(Branch_Taken_i), .Mem_Ready_i(Mem_Ready_i),
    .Mem_Req_o(Mem_Req_o), .Freeze_o(Freeze_o), .Bubble_MEMWB_o(Bubble_MEMWB_o),
    .Stall_FD_o(Stall_FD_o), .Flush_IFID_o(Flush_IFID_o), .Flush_IDEX_o(Flush_IDEX_o),
    .FwdA_o(FwdA_o), .FwdB_o(FwdB_o), .Mem_Err_o(Mem_Err_o), .State_o(State_o),
    .Stall_Cnt_o(Stall_Cnt_o)
  );

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  exp_t          sb_q[$];
  string         nm_q[$];
  logic [CW-1:0] exp_cnt = '0;

  function automatic exp_t mk(input logic req, input logic frz, input logic stl,
                              input logic fif, input logic fid, input logic [1:0] fa,
                              input logic [1:0] fb, input logic err, input logic [1:0] st);
    exp_t e;
    e          = '0;
    e.req      = req;
    e.freeze   = frz;
    e.bubble   = frz;
    e.stall_fd = stl;
    e.fl_ifid  = fif;
    e.fl_idex  = fid;
    e.fwda     = fa;
    e.fwdb     = fb;
    e.err      = err;
    e.state    = st;
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("req=%b frz=%b bub=%b stl=%b fif=%b fid=%b fa=%b fb=%b err=%b st=%b cnt=%0d",
                     e.req, e.freeze, e.bubble, e.stall_fd, e.fl_ifid, e.fl_idex,
                     e.fwda, e.fwdb, e.err, e.state, e.cnt);
  endfunction

  task automatic step(input in_t v, input exp_t e, input string nm);
    exp_t  got, want;
    string wn;
    @(posedge CLK);
    #1;
    RST = v.rst;
    IDEX_A1_i = v.a1; IDEX_A2_i = v.a2; IDEX_A3_i = v.a3;
    IDEX_RF_WE_i = v.idex_we; IDEX_WBSelect_i = v.idex_wb;
    ID_A1_i = v.id_a1; ID_A2_i = v.id_a2; ID_Use1_i = v.use1; ID_Use2_i = v.use2;
    EXMEM_A3_i = v.exmem_a3; EXMEM_RF_WE_i = v.exmem_we;
    EXMEM_WBSelect_i = v.exmem_wb; EXMEM_MemWE_i = v.exmem_mwe;
    MEMWB_A3_i = v.memwb_a3; MEMWB_RF_WE_i = v.memwb_we;
    Branch_Taken_i = v.branch; Mem_Ready_i = v.ready;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge CLK);
    want = sb_q.pop_front();
    wn   = nm_q.pop_front();
    got.req = Mem_Req_o;       got.freeze = Freeze_o;      got.bubble = Bubble_MEMWB_o;
    got.stall_fd = Stall_FD_o; got.fl_ifid = Flush_IFID_o; got.fl_idex = Flush_IDEX_o;
    got.fwda = FwdA_o;         got.fwdb = FwdB_o;          got.err = Mem_Err_o;
    got.state = State_o;       got.cnt = Stall_Cnt_o;
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %s, expected %s", wn, fmt(got), fmt(want));
    end
    if (!v.rst) exp_cnt = '0;
    else if ((want.freeze | want.stall_fd) && (exp_cnt != '1)) exp_cnt = exp_cnt + CW'(1);
  endtask

  initial begin
    vec_t tbl[13];
    in_t  idle, v;

    idle = '0;
    idle.rst = 1'b1;

    tbl[0].vi = idle; tbl[0].nm = "idle";
    tbl[0].ve = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00);

    v = idle; v.a1 = 3; v.a2 = 3; v.exmem_we = 1; v.exmem_a3 = 3; v.memwb_we = 1; v.memwb_a3 = 3;
    tbl[1].vi = v; tbl[1].nm = "fwd_exmem_priority";
    tbl[1].ve = mk(0, 0, 0, 0, 0, 2'b01, 2'b01, 0, 2'b00);

    v.exmem_wb = 1; v.ready = 1;
    tbl[2].vi = v; tbl[2].nm = "fwd_load_in_exmem_zero_wait";
    tbl[2].ve = mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 0, 2'b00);

    v = idle; v.a1 = 3; v.a2 = 7; v.exmem_we = 1; v.exmem_a3 = 3; v.memwb_we = 1; v.memwb_a3 = 7;
    tbl[3].vi = v; tbl[3].nm = "fwd_split";
    tbl[3].ve = mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 2'b00);

    v = idle; v.a1 = 3; v.exmem_a3 = 3; v.memwb_we = 1; v.memwb_a3 = 3;
    tbl[4].vi = v; tbl[4].nm = "fwd_exmem_no_we";
    tbl[4].ve = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00);

    v.memwb_we = 0;
    tbl[5].vi = v; tbl[5].nm = "fwd_none";
    tbl[5].ve = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00);

    v = idle; v.idex_wb = 1; v.idex_we = 1; v.a3 = 5; v.id_a1 = 5; v.use1 = 1;
    tbl[6].vi = v; tbl[6].nm = "load_use_a1";
    tbl[6].ve = mk(0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 2'b00);

    v.id_a1 = 2; v.id_a2 = 5; v.use2 = 1;
    tbl[7].vi = v; tbl[7].nm = "load_use_a2";
    tbl[7].ve = mk(0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 2'b00);

    v.id_a1 = 5; v.use1 = 0; v.use2 = 0;
    tbl[8].vi = v; tbl[8].nm = "load_use_unused_src";
    tbl[8].ve = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00);

    v.use1 = 1; v.idex_we = 0;
    tbl[9].vi = v; tbl[9].nm = "load_use_no_rf_we";
    tbl[9].ve = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00);

    v.idex_we = 1; v.branch = 1;
    tbl[10].vi = v; tbl[10].nm = "branch_over_load_use";
    tbl[10].ve = mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 2'b00);

    v = idle; v.branch = 1;
    tbl[11].vi = v; tbl[11].nm = "branch_only";
    tbl[11].ve = mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 2'b00);

    v = idle; v.exmem_mwe = 1; v.ready = 1;
    tbl[12].vi = v; tbl[12].nm = "store_zero_wait";
    tbl[12].ve = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00);

    RST = 1'b0;
    {IDEX_A1_i, IDEX_A2_i, IDEX_A3_i, ID_A1_i, ID_A2_i, EXMEM_A3_i, MEMWB_A3_i} = '0;
    {IDEX_RF_WE_i, IDEX_WBSelect_i, ID_Use1_i, ID_Use2_i} = '0;
    {EXMEM_RF_WE_i, EXMEM_WBSelect_i, EXMEM_MemWE_i, MEMWB_RF_WE_i} = '0;
    {Branch_Taken_i, Mem_Ready_i} = '0;
    repeat (2) @(posedge CLK);

    // Reset forces outputs low despite active memop, branch and forwarding matches
    v = idle; v.rst = 0; v.exmem_wb = 1; v.exmem_we = 1; v.exmem_a3 = 3; v.a1 = 3;
    v.memwb_we = 1; v.memwb_a3 = 3; v.branch = 1;
    step(v, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), "reset_c1");
    step(v, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), "reset_c2");
    v.rst = 1;
    step(v, mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00), "release_first_req");
    v.ready = 1;
    step(v, mk(0, 0, 0, 1, 1, 2'b10, 2'b00, 0, 2'b01), "release_branch_flush");
    v.branch = 0;
    step(v, mk(1, 0, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00), "back_to_back_req");

    for (int i = 0; i < 13; i++) step(tbl[i].vi, tbl[i].ve, tbl[i].nm);

    // Three wait cycles with a taken branch held in the frozen EX stage
    v = idle; v.exmem_wb = 1; v.branch = 1;
    step(v, mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), "wait3_req");
    step(v, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01), "wait3_w1");
    step(v, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01), "wait3_w2");
    v.ready = 1;
    step(v, mk(0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 2'b01), "wait3_release");
    step(idle, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), "wait3_back_to_run");

    // Timeout into sticky error, counter saturation, then recovery by reset
    v = idle; v.exmem_mwe = 1;
    step(v, mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), "tmo_req");
    for (int i = 0; i < 3; i++)
      step(v, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01), $sformatf("tmo_wait%0d", i + 1));
    v.ready = 1;
    step(v, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10), "tmo_err_entered");
    v = idle; v.ready = 1;
    for (int i = 0; i < 14; i++)
      step(v, mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10), $sformatf("err_sticky%0d", i));
    v.rst = 0; v.branch = 1;
    step(v, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10), "err_reset_edge");
    step(idle, mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00), "err_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
